// File: rtl/moore_vending_param.sv
// Parametrised Moore vending controller: accumulates coin credit, dispenses at PRICE,
// returns change or refunds on cancel. All outputs are registered decodes of the next state.
//
// state  | meaning
// IDLE   | no credit held, waiting for coins
// ACCUM  | partial credit held in credit register
// VEND   | dispense pulse (x), change amount latched
// CHANGE | change pulse (y) with change amount
// REFUND | refund pulse (y) with accumulated credit
module moore_vending_param #(
  parameter int PRICE  = 3,
  parameter int COIN_A = 1,
  parameter int COIN_B = 2,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i,
  input  logic          j,
  input  logic          cancel,
  output logic          x,
  output logic          y,
  output logic [CW-1:0] change,
  output logic [CW-1:0] credit,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    VEND   = 3'd2,
    CHANGE = 3'd3,
    REFUND = 3'd4
  } state_t;

  localparam logic [CW-1:0] PRICE_C  = CW'(PRICE);
  localparam logic [CW:0]   PRICE_W  = (CW+1)'(PRICE);
  localparam logic [CW:0]   COIN_A_W = (CW+1)'(COIN_A);
  localparam logic [CW:0]   COIN_B_W = (CW+1)'(COIN_B);

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [CW-1:0] amt_q, amt_d;
  logic          x_q, x_d;
  logic          y_q, y_d;
  logic [CW-1:0] change_q, change_d;
  logic [CW-1:0] credit_out_q, credit_out_d;
  logic          busy_q, busy_d;

  logic [CW:0]   sum;

  // One extra bit keeps the compare against PRICE exact for any coin combination.
  always_comb begin
    sum = {1'b0, credit_q};
    if (i) sum = sum + COIN_A_W;
    if (j) sum = sum + COIN_B_W;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    amt_d    = amt_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (sum >= PRICE_W) begin
          state_d  = VEND;
          amt_d    = sum[CW-1:0] - PRICE_C;
          credit_d = '0;
        end else if (cancel && (sum != '0)) begin
          state_d  = REFUND;
          amt_d    = sum[CW-1:0];
          credit_d = '0;
        end else if (sum != '0) begin
          state_d  = ACCUM;
          credit_d = sum[CW-1:0];
        end
      end
      VEND: begin
        credit_d = '0;
        if (amt_q != '0) begin
          state_d = CHANGE;
        end else begin
          state_d = IDLE;
          amt_d   = '0;
        end
      end
      CHANGE, REFUND: begin
        state_d  = IDLE;
        credit_d = '0;
        amt_d    = '0;
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
        amt_d    = '0;
      end
    endcase
  end

  // Outputs decoded from next-state values so the registered copies line up with state_q.
  always_comb begin
    x_d          = (state_d == VEND);
    y_d          = (state_d == CHANGE) || (state_d == REFUND);
    busy_d       = (state_d == VEND) || (state_d == CHANGE) || (state_d == REFUND);
    change_d     = y_d ? amt_d : '0;
    credit_out_d = (state_d == ACCUM) ? credit_d : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      credit_q     <= '0;
      amt_q        <= '0;
      x_q          <= 1'b0;
      y_q          <= 1'b0;
      change_q     <= '0;
      credit_out_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      amt_q        <= amt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      change_q     <= change_d;
      credit_out_q <= credit_out_d;
      busy_q       <= busy_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign change = change_q;
  assign credit = credit_out_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_moore_vending_param.sv
// Directed bench for moore_vending_param at default parameters (PRICE=3, A=1, B=2, CW=4).
module tb_moore_vending_param;

  logic       clk;
  logic       rst;
  logic       i;
  logic       j;
  logic       cancel;
  logic       x;
  logic       y;
  logic [3:0] change;
  logic [3:0] credit;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  moore_vending_param #(
    .PRICE(3), .COIN_A(1), .COIN_B(2), .CW(4)
  ) dut (
    .clk(clk), .rst(rst), .i(i), .j(j), .cancel(cancel),
    .x(x), .y(y), .change(change), .credit(credit), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic ii, input logic jj, input logic cc);
    i = ii; j = jj; cancel = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic ex_x, input logic ex_y,
                     input logic [3:0] ex_ch, input logic [3:0] ex_cr, input logic ex_b);
    n_cmp++;
    assert (x === ex_x) else begin
      n_err++; $error("FAIL %s x: got %0b want %0b", tag, x, ex_x);
    end
    n_cmp++;
    assert (y === ex_y) else begin
      n_err++; $error("FAIL %s y: got %0b want %0b", tag, y, ex_y);
    end
    n_cmp++;
    assert (change === ex_ch) else begin
      n_err++; $error("FAIL %s change: got %0d want %0d", tag, change, ex_ch);
    end
    n_cmp++;
    assert (credit === ex_cr) else begin
      n_err++; $error("FAIL %s credit: got %0d want %0d", tag, credit, ex_cr);
    end
    n_cmp++;
    assert (busy === ex_b) else begin
      n_err++; $error("FAIL %s busy: got %0b want %0b", tag, busy, ex_b);
    end
  endtask

  initial begin
    rst = 1'b0; i = 1'b0; j = 1'b0; cancel = 1'b0;
    #2;
    chk("in_reset", 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    cyc(0, 0, 0); chk("rst_idle0", 0, 0, 0, 0, 0);
    cyc(0, 0, 0); chk("rst_idle1", 0, 0, 0, 0, 0);
    cyc(0, 0, 0); chk("rst_idle2", 0, 0, 0, 0, 0);

    // exact price with three A coins
    cyc(1, 0, 0); chk("exact_c1", 0, 0, 0, 1, 0);
    cyc(1, 0, 0); chk("exact_c2", 0, 0, 0, 2, 0);
    cyc(1, 0, 0); chk("exact_vend", 1, 0, 0, 0, 1);
    cyc(0, 0, 0); chk("exact_idle", 0, 0, 0, 0, 0);
    cyc(0, 0, 0); chk("exact_idle2", 0, 0, 0, 0, 0);

    // overpay with two B coins: change 1
    cyc(0, 1, 0); chk("over_c2", 0, 0, 0, 2, 0);
    cyc(0, 1, 0); chk("over_vend", 1, 0, 0, 0, 1);
    cyc(0, 0, 0); chk("over_change", 0, 1, 1, 0, 1);
    cyc(0, 0, 0); chk("over_idle", 0, 0, 0, 0, 0);

    // simultaneous A+B from IDLE
    cyc(1, 1, 0); chk("both_vend", 1, 0, 0, 0, 1);
    cyc(0, 0, 0); chk("both_idle", 0, 0, 0, 0, 0);

    // i then cancel, with an idle hold in ACCUM
    cyc(1, 0, 0); chk("cxl_c1", 0, 0, 0, 1, 0);
    cyc(0, 0, 0); chk("cxl_hold", 0, 0, 0, 1, 0);
    cyc(0, 0, 1); chk("cxl_refund", 0, 1, 1, 0, 1);
    cyc(0, 0, 0); chk("cxl_idle", 0, 0, 0, 0, 0);

    // cancel with no credit is ignored
    cyc(0, 0, 1); chk("cxl_zero0", 0, 0, 0, 0, 0);
    cyc(0, 0, 1); chk("cxl_zero1", 0, 0, 0, 0, 0);

    // coin and cancel together from IDLE
    cyc(1, 0, 1); chk("cxl_same", 0, 1, 1, 0, 1);
    cyc(0, 0, 0); chk("cxl_same_idle", 0, 0, 0, 0, 0);

    // refund of a larger credit
    cyc(0, 1, 0); chk("ref2_c2", 0, 0, 0, 2, 0);
    cyc(0, 0, 1); chk("ref2_refund", 0, 1, 2, 0, 1);
    cyc(0, 0, 0); chk("ref2_idle", 0, 0, 0, 0, 0);

    // vend beats cancel
    cyc(0, 1, 0); chk("prio_c2", 0, 0, 0, 2, 0);
    cyc(1, 0, 1); chk("prio_vend", 1, 0, 0, 0, 1);
    cyc(0, 0, 0); chk("prio_idle", 0, 0, 0, 0, 0);

    // largest pre-vend sum: 2 + 1 + 2 = 5, change 2
    cyc(0, 1, 0); chk("max_c2", 0, 0, 0, 2, 0);
    cyc(1, 1, 0); chk("max_vend", 1, 0, 0, 0, 1);
    cyc(0, 0, 0); chk("max_change", 0, 1, 2, 0, 1);
    cyc(0, 0, 0); chk("max_idle", 0, 0, 0, 0, 0);

    // coins lost while busy
    cyc(0, 1, 0); chk("busy_c2", 0, 0, 0, 2, 0);
    cyc(0, 1, 0); chk("busy_vend", 1, 0, 0, 0, 1);
    cyc(1, 0, 0); chk("busy_change", 0, 1, 1, 0, 1);
    cyc(1, 0, 0); chk("busy_idle", 0, 0, 0, 0, 0);
    cyc(1, 0, 0); chk("busy_after", 0, 0, 0, 1, 0);
    cyc(0, 0, 1); chk("busy_refund", 0, 1, 1, 0, 1);
    cyc(0, 0, 0); chk("busy_clear", 0, 0, 0, 0, 0);

    // reset asserted during VEND
    cyc(0, 1, 0); chk("rv_c2", 0, 0, 0, 2, 0);
    cyc(0, 1, 0); chk("rv_vend", 1, 0, 0, 0, 1);
    i = 1'b0; j = 1'b0; cancel = 1'b0;
    rst = 1'b0;
    #1;
    chk("rv_async", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("rv_held", 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    cyc(0, 0, 0); chk("rv_post0", 0, 0, 0, 0, 0);
    cyc(0, 0, 0); chk("rv_post1", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
